// File: rtl/rtc_calendar.sv
// rtc_calendar: real-time clock/calendar with a CLK_HZ prescaler, Gregorian
// leap-year rules, validated loads, a 12-hour display view and one alarm.
//
// Ports:
//   clk, reset            system clock, async active-high reset
//   load, set_*           load request and time/date values (validated)
//   alarm_load            capture set_hour/set_min as the alarm time
//   alarm_en              alarm enable
//   hour..year            current time and date (registered)
//   disp_hour, pm         12-hour view, combinational from the registers
//   tick                  one-cycle pulse per second advance
//   load_err              one-cycle pulse when a load or alarm load is rejected
//   alarm_fire            one-cycle pulse when the alarm time is reached
module rtc_calendar #(
  parameter int unsigned CLK_HZ     = 1,
  parameter int unsigned YEAR_W     = 12,
  parameter int unsigned RESET_YEAR = 2020
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4:0]        set_hour,
  input  logic [5:0]        set_min,
  input  logic [5:0]        set_sec,
  input  logic [4:0]        set_day,
  input  logic [3:0]        set_month,
  input  logic [YEAR_W-1:0] set_year,
  input  logic              alarm_load,
  input  logic              alarm_en,
  output logic [4:0]        hour,
  output logic [5:0]        min,
  output logic [5:0]        sec,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        disp_hour,
  output logic              pm,
  output logic              tick,
  output logic              load_err,
  output logic              alarm_fire
);

  localparam int unsigned PCNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(CLK_HZ - 1);

  // Gregorian leap year; constant-divisor modulo resolves to plain logic
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] y32;
    y32 = 32'(y);
    return (((y32 % 32'd4) == 32'd0) && ((y32 % 32'd100) != 32'd0)) ||
           ((y32 % 32'd400) == 32'd0);
  endfunction

  // Days in month m of year y
  function automatic logic [4:0] dim(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    logic [4:0] r;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: r = 5'd30;
      4'd2:                    r = is_leap(y) ? 5'd29 : 5'd28;
      default:                 r = 5'd31;
    endcase
    return r;
  endfunction

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [4:0]        hour_q, hour_d;
  logic [5:0]        min_q, min_d;
  logic [5:0]        sec_q, sec_d;
  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic [4:0]        alarm_hour_q, alarm_hour_d;
  logic [5:0]        alarm_min_q, alarm_min_d;
  logic              tick_q, tick_d;
  logic              load_err_q, load_err_d;
  logic              alarm_fire_q, alarm_fire_d;

  logic              wrap;
  logic              set_valid;
  logic              alarm_valid;

  assign wrap = (pcnt_q == PCNT_MAX);

  // Load validation against the day count of the requested month/year
  always_comb begin
    set_valid = 1'b0;
    alarm_valid = 1'b0;
    set_valid = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59) &&
                (set_month >= 4'd1) && (set_month <= 4'd12) &&
                (set_day >= 5'd1) && (set_day <= dim(set_month, set_year));
    alarm_valid = (set_hour <= 5'd23) && (set_min <= 6'd59);
  end

  // Next state: a valid load wins over a same-edge advance
  always_comb begin
    pcnt_d       = wrap ? '0 : pcnt_q + PCNT_W'(1);
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    tick_d       = 1'b0;
    alarm_fire_d = 1'b0;
    load_err_d   = (load && !set_valid) || (alarm_load && !alarm_valid);

    if (load && set_valid) begin
      pcnt_d  = '0;
      hour_d  = set_hour;
      min_d   = set_min;
      sec_d   = set_sec;
      day_d   = set_day;
      month_d = set_month;
      year_d  = set_year;
    end else if (wrap) begin
      tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d = 5'd0;
            if (day_q >= dim(month_q, year_q)) begin
              day_d = 5'd1;
              if (month_q >= 4'd12) begin
                month_d = 4'd1;
                year_d  = year_q + YEAR_W'(1);
              end else begin
                month_d = month_q + 4'd1;
              end
            end else begin
              day_d = day_q + 5'd1;
            end
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
        // Only an advance onto second zero can match the alarm
        alarm_fire_d = alarm_en && (hour_d == alarm_hour_q) && (min_d == alarm_min_q);
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (alarm_load && alarm_valid) begin
      alarm_hour_d = set_hour;
      alarm_min_d  = set_min;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q       <= '0;
      hour_q       <= 5'd0;
      min_q        <= 6'd0;
      sec_q        <= 6'd0;
      day_q        <= 5'd1;
      month_q      <= 4'd1;
      year_q       <= YEAR_W'(RESET_YEAR);
      alarm_hour_q <= 5'd0;
      alarm_min_q  <= 6'd0;
      tick_q       <= 1'b0;
      load_err_q   <= 1'b0;
      alarm_fire_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      tick_q       <= tick_d;
      load_err_q   <= load_err_d;
      alarm_fire_q <= alarm_fire_d;
    end
  end

  // 12-hour view: 0 -> 12, 13..23 -> 1..11
  always_comb begin
    disp_hour = 4'(hour_q);
    if (hour_q == 5'd0) begin
      disp_hour = 4'd12;
    end else if (hour_q > 5'd12) begin
      disp_hour = 4'(hour_q - 5'd12);
    end
  end

  assign pm         = (hour_q >= 5'd12);
  assign hour       = hour_q;
  assign min        = min_q;
  assign sec        = sec_q;
  assign day        = day_q;
  assign month      = month_q;
  assign year       = year_q;
  assign tick       = tick_q;
  assign load_err   = load_err_q;
  assign alarm_fire = alarm_fire_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Self-checking bench for rtc_calendar: u0 runs at CLK_HZ=4, u1 at CLK_HZ=1
// for the load/wrap collision case. Expected snapshots are queued when the
// stimulus is driven and popped when the DUT output is sampled (negedge).
module tb_rtc_calendar;

  typedef struct packed {
    logic [4:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [3:0]  disp;
    logic        pm;
    logic        tick;
    logic        err;
    logic        fire;
  } snap_t;

  logic        clk, reset, load, load1, alarm_load, alarm_en;
  logic [4:0]  set_hour;
  logic [5:0]  set_min, set_sec;
  logic [4:0]  set_day;
  logic [3:0]  set_month;
  logic [11:0] set_year;

  logic [4:0]  hour0, day0, hour1, day1;
  logic [5:0]  min0, sec0, min1, sec1;
  logic [3:0]  month0, disp0, month1, disp1;
  logic [11:0] year0, year1;
  logic        pm0, tick0, err0, fire0, pm1, tick1, err1, fire1;

  snap_t exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  rtc_calendar #(.CLK_HZ(4), .YEAR_W(12), .RESET_YEAR(2020)) u0 (
    .clk(clk), .reset(reset), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .alarm_load(alarm_load), .alarm_en(alarm_en),
    .hour(hour0), .min(min0), .sec(sec0), .day(day0), .month(month0), .year(year0),
    .disp_hour(disp0), .pm(pm0), .tick(tick0), .load_err(err0), .alarm_fire(fire0)
  );

  rtc_calendar #(.CLK_HZ(1), .YEAR_W(12), .RESET_YEAR(2020)) u1 (
    .clk(clk), .reset(reset), .load(load1),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .alarm_load(1'b0), .alarm_en(1'b0),
    .hour(hour1), .min(min1), .sec(sec1), .day(day1), .month(month1), .year(year1),
    .disp_hour(disp1), .pm(pm1), .tick(tick1), .load_err(err1), .alarm_fire(fire1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input int h, input int m, input int s, input int d,
                               input int mo, input int y, input bit tk, input bit er,
                               input bit fi);
    snap_t r;
    int dv;
    dv = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    r.hour = 5'(h); r.min = 6'(m); r.sec = 6'(s); r.day = 5'(d);
    r.month = 4'(mo); r.year = 12'(y); r.disp = 4'(dv); r.pm = (h >= 12);
    r.tick = tk; r.err = er; r.fire = fi;
    return r;
  endfunction

  function automatic snap_t obs0();
    snap_t r;
    r.hour = hour0; r.min = min0; r.sec = sec0; r.day = day0; r.month = month0;
    r.year = year0; r.disp = disp0; r.pm = pm0; r.tick = tick0; r.err = err0;
    r.fire = fire0;
    return r;
  endfunction

  function automatic snap_t obs1();
    snap_t r;
    r.hour = hour1; r.min = min1; r.sec = sec1; r.day = day1; r.month = month1;
    r.year = year1; r.disp = disp1; r.pm = pm1; r.tick = tick1; r.err = err1;
    r.fire = fire1;
    return r;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("%0d:%0d:%0d %0d-%0d-%0d disp=%0d pm=%0b tick=%0b err=%0b fire=%0b",
                     s.hour, s.min, s.sec, s.day, s.month, s.year, s.disp, s.pm,
                     s.tick, s.err, s.fire);
  endfunction

  task automatic drive_set(input int h, input int m, input int s, input int d,
                           input int mo, input int y);
    set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    set_day = 5'(d); set_month = 4'(mo); set_year = 12'(y);
  endtask

  task automatic apply_load(input int h, input int m, input int s, input int d,
                            input int mo, input int y);
    drive_set(h, m, s, d, mo, y);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    snap_t e, o; string n;
    reset = 1'b1; load = 1'b0; load1 = 1'b0; alarm_load = 1'b0; alarm_en = 1'b0;
    drive_set(0, 0, 0, 1, 1, 2020);
    wait_cycles(2);
    exp_q.push_back(mk(0, 0, 0, 1, 1, 2020, 0, 0, 0)); name_q.push_back("reset_state");
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      exp_q.push_back(mk(0, 0, c / 4, 1, 1, 2020, (c % 4) == 0, 0, 0));
      name_q.push_back($sformatf("reset_count_%0d", c));
      @(negedge clk);
      e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    end
    // Reset partway through a count restarts the prescaler
    wait_cycles(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      exp_q.push_back(mk(0, 0, c / 4, 1, 1, 2020, c == 4, 0, 0));
      name_q.push_back($sformatf("midreset_count_%0d", c));
      @(negedge clk);
      e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_year_rollover();
    snap_t e, o; string n;
    exp_q.push_back(mk(23, 59, 59, 31, 12, 2020, 0, 0, 0)); name_q.push_back("roll_load");
    apply_load(23, 59, 59, 31, 12, 2020);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    wait_cycles(3);
    exp_q.push_back(mk(0, 0, 0, 1, 1, 2021, 1, 0, 0)); name_q.push_back("roll_advance");
    @(negedge clk);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
  endtask

  task automatic test_leap();
    snap_t e, o; string n;
    int ly[4]  = '{2024, 2100, 2000, 2024};
    int ld[4]  = '{28, 28, 28, 29};
    int ed[4]  = '{29, 1, 29, 1};
    int emo[4] = '{2, 3, 2, 3};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(23, 59, 59, ld[i], 2, ly[i], 0, 0, 0));
      name_q.push_back($sformatf("leap_load_%0d_%0d", ld[i], ly[i]));
      apply_load(23, 59, 59, ld[i], 2, ly[i]);
      e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
      wait_cycles(3);
      exp_q.push_back(mk(0, 0, 0, ed[i], emo[i], ly[i], 1, 0, 0));
      name_q.push_back($sformatf("leap_adv_%0d_%0d", ld[i], ly[i]));
      @(negedge clk);
      e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_invalid_load();
    snap_t e, o; string n;
    // Rejected loads at steps 1,4,5,7; step 4 coincides with a prescaler wrap
    bit lf[8]  = '{1, 0, 0, 1, 1, 0, 1, 0};
    int ih[8]  = '{12, 12, 12, 12, 24, 12, 12, 12};
    int id[8]  = '{31, 15, 15, 29, 15, 15, 15, 15};
    int imo[8] = '{4, 6, 6, 2, 6, 6, 0, 6};
    int iy[8]  = '{2021, 2021, 2021, 2023, 2021, 2021, 2021, 2021};
    exp_q.push_back(mk(12, 0, 0, 15, 6, 2021, 0, 0, 0)); name_q.push_back("inv_base_load");
    apply_load(12, 0, 0, 15, 6, 2021);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    for (int i = 0; i < 8; i++) begin
      drive_set(ih[i], 0, 0, id[i], imo[i], iy[i]);
      load = lf[i];
      exp_q.push_back(mk(12, 0, (i + 1) / 4, 15, 6, 2021, ((i + 1) % 4) == 0, lf[i], 0));
      name_q.push_back($sformatf("invalid_step_%0d", i + 1));
      @(negedge clk);
      load = 1'b0;
      e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_alarm();
    snap_t e, o; string n;
    drive_set(7, 30, 0, 1, 1, 2021);
    alarm_load = 1'b1;
    @(negedge clk);
    alarm_load = 1'b0;
    n_checks++;
    if (err0 !== 1'b0) begin n_errors++; $display("FAIL alarm_set_err: got %0b expected 0", err0); end
    alarm_en = 1'b1;
    exp_q.push_back(mk(7, 29, 58, 1, 1, 2021, 0, 0, 0)); name_q.push_back("alarm_load_2958");
    apply_load(7, 29, 58, 1, 1, 2021);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    wait_cycles(3);
    exp_q.push_back(mk(7, 29, 59, 1, 1, 2021, 1, 0, 0)); name_q.push_back("alarm_2959");
    @(negedge clk);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    wait_cycles(3);
    exp_q.push_back(mk(7, 30, 0, 1, 1, 2021, 1, 0, 1)); name_q.push_back("alarm_fire_3000");
    @(negedge clk);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    exp_q.push_back(mk(7, 30, 0, 1, 1, 2021, 0, 0, 0)); name_q.push_back("alarm_pulse_end");
    @(negedge clk);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    wait_cycles(2);
    exp_q.push_back(mk(7, 30, 1, 1, 1, 2021, 1, 0, 0)); name_q.push_back("alarm_3001");
    @(negedge clk);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    // Disabled alarm stays quiet
    alarm_en = 1'b0;
    exp_q.push_back(mk(7, 29, 59, 1, 1, 2021, 0, 0, 0)); name_q.push_back("alarm_dis_load");
    apply_load(7, 29, 59, 1, 1, 2021);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    wait_cycles(3);
    exp_q.push_back(mk(7, 30, 0, 1, 1, 2021, 1, 0, 0)); name_q.push_back("alarm_dis_3000");
    @(negedge clk);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    // Loading the alarm time directly never fires
    alarm_en = 1'b1;
    exp_q.push_back(mk(7, 30, 0, 1, 1, 2021, 0, 0, 0)); name_q.push_back("alarm_direct_load");
    apply_load(7, 30, 0, 1, 1, 2021);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    // Load and alarm_load together: alarm moves to 07:29, so 07:30:00 is silent
    drive_set(7, 29, 59, 1, 1, 2021);
    load = 1'b1; alarm_load = 1'b1;
    exp_q.push_back(mk(7, 29, 59, 1, 1, 2021, 0, 0, 0)); name_q.push_back("alarm_both_load");
    @(negedge clk);
    load = 1'b0; alarm_load = 1'b0;
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    wait_cycles(3);
    exp_q.push_back(mk(7, 30, 0, 1, 1, 2021, 1, 0, 0)); name_q.push_back("alarm_moved_3000");
    @(negedge clk);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    // Out-of-range alarm is rejected and leaves 07:29 armed
    drive_set(24, 0, 0, 1, 1, 2021);
    alarm_load = 1'b1;
    @(negedge clk);
    alarm_load = 1'b0;
    n_checks++;
    if (err0 !== 1'b1) begin n_errors++; $display("FAIL alarm_bad_err: got %0b expected 1", err0); end
    exp_q.push_back(mk(7, 28, 59, 1, 1, 2021, 0, 0, 0)); name_q.push_back("alarm_2859_load");
    apply_load(7, 28, 59, 1, 1, 2021);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    wait_cycles(3);
    exp_q.push_back(mk(7, 29, 0, 1, 1, 2021, 1, 0, 1)); name_q.push_back("alarm_fire_2900");
    @(negedge clk);
    e = exp_q.pop_front(); n = name_q.pop_front(); o = obs0(); n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    alarm_en = 1'b0;
  endtask

  task automatic test_collision();
    snap_t e, o; string n;
    drive_set(10, 0, 0, 1, 1, 2021);
    load1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(10, 0, 0, 1, 1, 2021, 0, 0, 0));
      name_q.push_back($sformatf("collide_hold_%0d", i));
      @(negedge clk);
      e = exp_q.pop_front(); n = name_q.pop_front(); o = obs1(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    end
    load1 = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(mk(10, 0, i, 1, 1, 2021, 1, 0, 0));
      name_q.push_back($sformatf("collide_release_%0d", i));
      @(negedge clk);
      e = exp_q.pop_front(); n = name_q.pop_front(); o = obs1(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL %s: got %s expected %s", n, fmt(o), fmt(e)); end
    end
  endtask

  initial begin
    test_reset();
    test_year_rollover();
    test_leap();
    test_invalid_load();
    test_alarm();
    test_collision();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_calendar.md
# rtc_calendar

Parametrised real-time clock/calendar: the successor to the fixed 1 Hz `digital_clock`. A `CLK_HZ` prescaler derives the once-per-second tick from the system clock. The block keeps time and date with full Gregorian leap-year rules and rejects out-of-range loads. It also provides a 12-hour display view and one programmable alarm. It sits between the board clock and the display/console logic, which reads its registered outputs directly.

## Interface
- `CLK_HZ`, 1: `clk` cycles per second (≥1).
- `YEAR_W`, 12: year field width.
- `RESET_YEAR`, 2020: year loaded on reset (< 2^YEAR_W).

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; one clock; async active-high reset, fixed.
- `load` in 1: synchronous request to load the `set_*` fields.
- `set_hour` in 5, `set_min` in 6, `set_sec` in 6, `set_day` in 5, `set_month` in 4, `set_year` in YEAR_W: load values.
- `alarm_load` in 1: capture `set_hour`/`set_min` as the alarm time.
- `alarm_en` in 1: enables the alarm.
- `hour` out 5, `min` out 6, `sec` out 6, `day` out 5, `month` out 4, `year` out YEAR_W: current time and date, registered.
- `disp_hour` out 4: 12-hour view, 1..12.
- `pm` out 1: high when `hour` ≥ 12.
- `tick` out 1: one-cycle pulse on each second advance.
- `load_err` out 1: one-cycle pulse when a load is rejected.
- `alarm_fire` out 1: one-cycle alarm pulse.

## Operation
- Prescaler `pcnt` counts 0..CLK_HZ-1. When `pcnt`==CLK_HZ-1 it wraps to 0 and the second advances on that edge.
  - `tick` is registered high for exactly the cycle after the advance.
  - With CLK_HZ=1, time advances every cycle.
- Carry chain, evaluated in one cycle:
  - sec 59→0 carries to min; min 59→0 carries to hour; hour 23→0 carries to day.
  - day at `dim(month,year)` → 1 and carries to month; month 12→1 carries to year.
  - year at 2^YEAR_W-1 wraps to 0.
- Days in month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
- February has 29 days iff (year%4==0 and year%100!=0) or year%400==0, else 28.
  - The year arithmetic is YEAR_W-bit unsigned.
  - Constant-divisor modulo is implemented combinationally; it is not iterative.
- Load validation: valid iff all of the following hold:
  - hour ≤ 23, min ≤ 59, sec ≤ 59;
  - 1 ≤ month ≤ 12;
  - 1 ≤ day ≤ dim(set_month, set_year).
- Valid load:
  - All six fields take the `set_*` values on the next edge.
  - `pcnt` clears to 0.
  - No `tick` or `alarm_fire` is produced for that edge.
- Invalid load:
  - State and `pcnt` are unchanged; the prescaler keeps counting and a pending advance still occurs.
  - `load_err` pulses one cycle.
- `load` on the same edge as a prescaler wrap: a valid load wins and the advance is discarded.
- `alarm_load`: captures `alarm_hour` ≤ 23 and `alarm_min` ≤ 59.
  - Out-of-range values are ignored and pulse `load_err`.
  - Reset alarm value is 00:00.
  - `load` and `alarm_load` together: both are validated and applied independently; `load_err` is their OR.
- Alarm match: `alarm_fire` pulses (registered, same cycle as `tick`) when an advance produces sec==0 and hour/min equal the alarm time, with `alarm_en`=1.
  - Loads never fire the alarm.
- 12-hour view, combinational from the registers: `disp_hour` = 12 if hour==0, hour-12 if hour>12, else hour.

## Timing
- Reset (async assert, released synchronously by the clock domain):
  - 00:00:00, 01-01-RESET_YEAR; `pcnt`=0.
  - `tick`, `load_err`, `alarm_fire` = 0; alarm time 00:00.
  - Derived outputs: `disp_hour`=12, `pm`=0.
- First advance: CLK_HZ cycles after reset release.
- Reset mid-count: abandons the partial count; the next advance is again CLK_HZ cycles after release.
- Load latency: 1 cycle, with outputs updated on the next edge. The next advance comes CLK_HZ cycles after the load edge.
- All outputs except `disp_hour`/`pm` are flops; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, CLK_HZ=4: hold reset, release → outputs 00:00:00 01-01-2020, `disp_hour`=12, `pm`=0; `tick` every 4th cycle; `sec`=1 after 4 cycles.
- Year rollover: load 23:59:59 31-12-2020, 1 advance → 00:00:00 01-01-2021; `pm` 1→0.
- Leap rules: from 23:59:59 28-02-Y, 1 advance gives:
  - Y=2024 → 29-02;
  - Y=2100 → 01-03;
  - Y=2000 → 29-02;
  - from 29-02-2024 23:59:59 → 01-03-2024.
- Invalid loads:
  - 31-04-2021 → `load_err`=1 for one cycle, time unchanged;
  - 29-02-2023 → rejected;
  - hour=24 → rejected;
  - month=0 → rejected.
- Alarm: alarm 07:30, `alarm_en`=1, load 07:29:58 → `alarm_fire` on the advance to 07:30:00 only. With `alarm_en`=0 → no pulse. Load of 07:30:00 directly → no pulse.
- Load/wrap collision, CLK_HZ=1: assert valid load 10:00:00 every cycle → outputs hold 10:00:00 and `tick` stays 0. Drop load → 10:00:01 on the next edge.
